// File: rtl/mem_pkg.sv
// Shared encodings for the memory access unit: operation codes, RV32I
// load/store width codes, FSM states and the byte-lane helpers.
package mem_pkg;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Access size as carried in funct3[1:0]
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Byte enables for an access of the given size at the given byte offset
  function automatic logic [3:0] byte_enable(input logic [1:0] size,
                                             input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << addr_lo;
      SZ_H:    be = 4'b0011 << addr_lo;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate store data across all lanes so the enabled lanes carry it
  function automatic logic [31:0] store_lanes(input logic [1:0]  size,
                                              input logic [31:0] data);
    logic [31:0] lanes;
    case (size)
      SZ_B:    lanes = {4{data[7:0]}};
      SZ_H:    lanes = {2{data[15:0]}};
      default: lanes = data;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half out of a read word and sign- or
// zero-extends it according to the load width code.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] result
);

  logic signed [7:0]  byte_sel;
  logic signed [15:0] half_sel;

  // Lane selection followed by extension
  always_comb begin
    byte_sel = 8'sh00;
    half_sel = 16'sh0000;
    result   = rdata;
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  result = {24'h000000, byte_sel};
      F3_LHU:  result = {16'h0000, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage of an RV32I pipeline: accepts one operation at a time from
// execute, issues aligned data-memory requests, formats store lanes,
// extends load data and hands a registered result to writeback.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter bit BLOCKING_STORE = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_mem_op,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_ALU_result,
  input  logic [31:0] in_store_data,
  input  logic [4:0]  in_rd,
  output logic        d_req,
  output logic        d_we,
  output logic [31:0] d_addr,
  output logic [3:0]  d_be,
  output logic [31:0] d_wdata,
  input  logic        d_gnt,
  input  logic        d_rvalid,
  input  logic [31:0] d_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_fault
);

  state_e      state_q, state_d;
  logic        d_req_q, d_req_d;
  logic        d_we_q, d_we_d;
  logic [31:0] d_addr_q, d_addr_d;
  logic [3:0]  d_be_q, d_be_d;
  logic [31:0] d_wdata_q, d_wdata_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_result_q, out_result_d;
  logic [4:0]  out_rd_q, out_rd_d;
  logic        out_fault_q, out_fault_d;

  // Context of the in-flight memory transaction
  logic        txn_load_q, txn_load_d;
  logic [2:0]  txn_funct3_q, txn_funct3_d;
  logic [31:0] txn_addr_q, txn_addr_d;
  logic [4:0]  txn_rd_q, txn_rd_d;

  logic        accept;
  logic        is_load;
  logic        is_store;
  logic        funct3_ok;
  logic        misaligned;
  logic        fault;
  logic [31:0] load_result;

  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign d_req      = d_req_q;
  assign d_we       = d_we_q;
  assign d_addr     = d_addr_q;
  assign d_be       = d_be_q;
  assign d_wdata    = d_wdata_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_rd     = out_rd_q;
  assign out_fault  = out_fault_q;

  load_extend u_load_extend (
    .rdata   (d_rdata),
    .funct3  (txn_funct3_q),
    .addr_lo (txn_addr_q[1:0]),
    .result  (load_result)
  );

  // Legality and alignment of the operation presented by execute
  always_comb begin
    is_load    = (in_mem_op == MEM_LOAD);
    is_store   = (in_mem_op == MEM_STORE);
    funct3_ok  = 1'b0;
    misaligned = 1'b0;
    if (is_load) begin
      funct3_ok = (in_funct3 == F3_LB) || (in_funct3 == F3_LH) ||
                  (in_funct3 == F3_LW) || (in_funct3 == F3_LBU) ||
                  (in_funct3 == F3_LHU);
    end else begin
      funct3_ok = (in_funct3 == F3_SB) || (in_funct3 == F3_SH) ||
                  (in_funct3 == F3_SW);
    end
    if (in_funct3[1:0] == SZ_H) begin
      misaligned = in_ALU_result[0];
    end else if (in_funct3[1:0] == SZ_W) begin
      misaligned = (in_ALU_result[1:0] != 2'b00);
    end
    fault = !funct3_ok || misaligned;
  end

  // Next-state and next-output computation for the request FSM
  always_comb begin
    state_d      = state_q;
    d_req_d      = d_req_q;
    d_we_d       = d_we_q;
    d_addr_d     = d_addr_q;
    d_be_d       = d_be_q;
    d_wdata_d    = d_wdata_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_rd_d     = out_rd_q;
    out_fault_d  = out_fault_q;
    txn_load_d   = txn_load_q;
    txn_funct3_d = txn_funct3_q;
    txn_addr_d   = txn_addr_q;
    txn_rd_d     = txn_rd_q;

    // Writeback took the current result; drop valid unless replaced below
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_load || is_store) begin
            if (fault) begin
              out_valid_d  = 1'b1;
              out_fault_d  = 1'b1;
              out_result_d = in_ALU_result;
              out_rd_d     = 5'd0;
            end else begin
              state_d      = ST_REQ;
              d_req_d      = 1'b1;
              d_we_d       = is_store;
              d_addr_d     = {in_ALU_result[31:2], 2'b00};
              d_be_d       = byte_enable(in_funct3[1:0], in_ALU_result[1:0]);
              d_wdata_d    = store_lanes(in_funct3[1:0], in_store_data);
              txn_load_d   = is_load;
              txn_funct3_d = in_funct3;
              txn_addr_d   = in_ALU_result;
              txn_rd_d     = in_rd;
            end
          end else begin
            out_valid_d  = 1'b1;
            out_fault_d  = 1'b0;
            out_result_d = in_ALU_result;
            out_rd_d     = in_rd;
          end
        end
      end
      ST_REQ: begin
        if (d_gnt) begin
          d_req_d = 1'b0;
          d_we_d  = 1'b0;
          if (txn_load_q || BLOCKING_STORE) begin
            state_d = ST_RESP;
          end else begin
            state_d      = ST_IDLE;
            out_valid_d  = 1'b1;
            out_fault_d  = 1'b0;
            out_result_d = txn_addr_q;
            out_rd_d     = 5'd0;
          end
        end
      end
      ST_RESP: begin
        if (d_rvalid) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b1;
          out_fault_d = 1'b0;
          if (txn_load_q) begin
            out_result_d = load_result;
            out_rd_d     = txn_rd_q;
          end else begin
            out_result_d = txn_addr_q;
            out_rd_d     = 5'd0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      d_req_q      <= 1'b0;
      d_we_q       <= 1'b0;
      d_addr_q     <= 32'h0;
      d_be_q       <= 4'h0;
      d_wdata_q    <= 32'h0;
      out_valid_q  <= 1'b0;
      out_result_q <= 32'h0;
      out_rd_q     <= 5'd0;
      out_fault_q  <= 1'b0;
      txn_load_q   <= 1'b0;
      txn_funct3_q <= 3'b000;
      txn_addr_q   <= 32'h0;
      txn_rd_q     <= 5'd0;
    end else begin
      state_q      <= state_d;
      d_req_q      <= d_req_d;
      d_we_q       <= d_we_d;
      d_addr_q     <= d_addr_d;
      d_be_q       <= d_be_d;
      d_wdata_q    <= d_wdata_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_rd_q     <= out_rd_d;
      out_fault_q  <= out_fault_d;
      txn_load_q   <= txn_load_d;
      txn_funct3_q <= txn_funct3_d;
      txn_addr_q   <= txn_addr_d;
      txn_rd_q     <= txn_rd_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with hand-computed expectations.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_mem_op;
  logic [2:0]  in_funct3;
  logic [31:0] in_ALU_result;
  logic [31:0] in_store_data;
  logic [4:0]  in_rd;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [3:0]  d_be;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_fault;

  int errors = 0;
  int checks = 0;

  mem_access_unit #(.BLOCKING_STORE(1'b0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_mem_op     (in_mem_op),
    .in_funct3     (in_funct3),
    .in_ALU_result (in_ALU_result),
    .in_store_data (in_store_data),
    .in_rd         (in_rd),
    .d_req         (d_req),
    .d_we          (d_we),
    .d_addr        (d_addr),
    .d_be          (d_be),
    .d_wdata       (d_wdata),
    .d_gnt         (d_gnt),
    .d_rvalid      (d_rvalid),
    .d_rdata       (d_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_rd        (out_rd),
    .out_fault     (out_fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [1:0] op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] rd);
    in_valid      = 1'b1;
    in_mem_op     = op;
    in_funct3     = f3;
    in_ALU_result = addr;
    in_store_data = sdata;
    in_rd         = rd;
  endtask

  // Load with immediate grant and earliest response
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [3:0] be,
                         input logic [31:0] exp, input logic [4:0] rd);
    present(2'b01, f3, addr, 32'h0, rd);
    d_gnt = 1'b1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check({tag, "_d_req"}, 32'(d_req), 32'd1);
    check({tag, "_d_addr"}, d_addr, {addr[31:2], 2'b00});
    check({tag, "_d_be"}, 32'(d_be), 32'(be));
    check({tag, "_d_we"}, 32'(d_we), 32'd0);
    tick();
    d_gnt = 1'b0;
    check({tag, "_req_drop"}, 32'(d_req), 32'd0);
    check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
    d_rvalid = 1'b1;
    d_rdata  = rdata;
    tick();
    d_rvalid = 1'b0;
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_out_result"}, out_result, exp);
    check({tag, "_out_rd"}, 32'(out_rd), 32'(rd));
    check({tag, "_out_fault"}, 32'(out_fault), 32'd0);
    tick();
    check({tag, "_consumed"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_mem_op = 2'b00; in_funct3 = 3'b000;
    in_ALU_result = 32'h0; in_store_data = 32'h0; in_rd = 5'd0;
    d_gnt = 1'b0; d_rvalid = 1'b0; d_rdata = 32'h0; out_ready = 1'b1;

    // Reset state
    tick(); tick();
    check("rst_d_req", 32'(d_req), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_d_be", 32'(d_be), 32'd0);
    check("rst_out_result", out_result, 32'h0);
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // LB 0x103, data 0x80FF_0000 -> 0xFFFF_FF80, out_valid at T+3
    do_load("lb", 3'b000, 32'h0000_0103, 32'h80FF_0000, 4'b1000, 32'hFFFF_FF80, 5'd5);
    do_load("lbu", 3'b100, 32'h0000_0101, 32'h0000_8000, 4'b0010, 32'h0000_0080, 5'd6);
    do_load("lh", 3'b001, 32'h0000_0002, 32'h8001_1234, 4'b1100, 32'hFFFF_8001, 5'd7);
    do_load("lhu", 3'b101, 32'h0000_000E, 32'h9ABC_0000, 4'b1100, 32'h0000_9ABC, 5'd8);
    do_load("lw", 3'b010, 32'h0000_0008, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 5'd9);

    // SH 0x202 with grant held off for 3 cycles
    present(2'b10, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 5'd7);
    tick();
    in_valid = 1'b0;
    in_store_data = 32'h0;
    for (int i = 0; i < 3; i++) begin
      check("sh_d_req", 32'(d_req), 32'd1);
      check("sh_d_we", 32'(d_we), 32'd1);
      check("sh_d_addr", d_addr, 32'h0000_0200);
      check("sh_d_be", 32'(d_be), 32'b1100);
      check("sh_d_wdata", d_wdata, 32'hABCD_ABCD);
      check("sh_no_valid", 32'(out_valid), 32'd0);
      if (i < 2) tick();
    end
    d_gnt = 1'b1;
    tick();
    d_gnt = 1'b0;
    check("sh_req_drop", 32'(d_req), 32'd0);
    check("sh_out_valid", 32'(out_valid), 32'd1);
    check("sh_out_rd", 32'(out_rd), 32'd0);
    check("sh_out_result", out_result, 32'h0000_0202);
    check("sh_in_ready", 32'(in_ready), 32'd1);

    // SB 0x301: byte replicated into every lane
    present(2'b10, 3'b000, 32'h0000_0301, 32'h0000_00A5, 5'd2);
    tick();
    in_valid = 1'b0;
    check("sb_d_be", 32'(d_be), 32'b0010);
    check("sb_d_wdata", d_wdata, 32'hA5A5_A5A5);
    check("sb_no_stale_valid", 32'(out_valid), 32'd0);
    d_gnt = 1'b1;
    tick();
    d_gnt = 1'b0;
    check("sb_out_valid", 32'(out_valid), 32'd1);
    tick();

    // LW 0x006 misaligned -> fault, no request
    present(2'b01, 3'b010, 32'h0000_0006, 32'h0, 5'd9);
    tick();
    in_valid = 1'b0;
    check("lwmis_d_req", 32'(d_req), 32'd0);
    check("lwmis_out_valid", 32'(out_valid), 32'd1);
    check("lwmis_out_fault", 32'(out_fault), 32'd1);
    check("lwmis_out_result", out_result, 32'h0000_0006);
    check("lwmis_out_rd", 32'(out_rd), 32'd0);
    tick();
    check("lwmis_consumed", 32'(out_valid), 32'd0);

    // Store with funct3 011 -> fault even though aligned
    present(2'b10, 3'b011, 32'h0000_0040, 32'h0, 5'd3);
    tick();
    in_valid = 1'b0;
    check("sbad_d_req", 32'(d_req), 32'd0);
    check("sbad_out_fault", 32'(out_fault), 32'd1);
    tick();

    // Non-memory op 0x55, writeback stalls for 2 cycles
    out_ready = 1'b0;
    present(2'b00, 3'b000, 32'h0000_0055, 32'h0, 5'd3);
    tick();
    present(2'b11, 3'b000, 32'h0000_0066, 32'h0, 5'd4);
    for (int i = 0; i < 2; i++) begin
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_result", out_result, 32'h0000_0055);
      check("stall_out_rd", 32'(out_rd), 32'd3);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("next_out_valid", 32'(out_valid), 32'd1);
    check("next_out_result", out_result, 32'h0000_0066);
    check("next_out_rd", 32'(out_rd), 32'd4);
    tick();
    check("next_consumed", 32'(out_valid), 32'd0);

    // LHU 0x10, reset while waiting for response, stray rvalid afterwards
    present(2'b01, 3'b101, 32'h0000_0010, 32'h0, 5'd8);
    d_gnt = 1'b1;
    tick();
    in_valid = 1'b0;
    check("lhu_d_req", 32'(d_req), 32'd1);
    tick();
    d_gnt = 1'b0;
    check("lhu_in_resp", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_d_req", 32'(d_req), 32'd0);
    check("arst_d_addr", d_addr, 32'h0);
    check("arst_d_be", 32'(d_be), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    d_rvalid = 1'b1;
    d_rdata  = 32'hDEAD_BEEF;
    tick();
    d_rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("stray_out_valid", 32'(out_valid), 32'd0);
      check("stray_out_result", out_result, 32'h0);
      check("stray_out_rd", 32'(out_rd), 32'd0);
      check("stray_out_fault", 32'(out_fault), 32'd0);
      check("stray_d_req", 32'(d_req), 32'd0);
      check("stray_in_ready", 32'(in_ready), 32'd1);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: BLOCKING_STORE, default 0, meaning 1 = stores complete on d_rvalid and 0 = stores complete on d_gnt.
REQ-002 clock  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1  execute stage presents an operation.
REQ-005 in_ready  out  1  unit accepts the operation this cycle.
REQ-006 in_mem_op  in  2  00 none, 01 load, 10 store, 11 treated as none.
REQ-007 in_funct3  in  3  RV32I load/store width code (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
REQ-008 in_ALU_result  in  32  ALU output: effective address for load/store, result otherwise.
REQ-009 in_store_data  in  32  rs2 value for stores.
REQ-010 in_rd  in  5  destination register.
REQ-011 d_req  out  1  data-memory request.
REQ-012 d_we  out  1  write enable.
REQ-013 d_addr  out  32  word address, bits [1:0] always 00.
REQ-014 d_be  out  4  byte enables.
REQ-015 d_wdata  out  32  lane-aligned store data.
REQ-016 d_gnt  in  1  memory accepted the request.
REQ-017 d_rvalid  in  1  response valid.
REQ-018 d_rdata  in  32  read word.
REQ-019 out_valid  out  1  writeback-stage result valid.
REQ-020 out_ready  in  1  writeback stage accepts the result.
REQ-021 out_result  out  32  writeback value.
REQ-022 out_rd  out  5  writeback register; 0 for stores and faults.
REQ-023 out_fault  out  1  misaligned access or illegal funct3.

Function
REQ-024 FSM states and transitions:
- IDLE -> REQ on an aligned load or store.
- REQ -> RESP (loads, or stores when BLOCKING_STORE=1) on d_gnt.
- REQ -> IDLE (stores when BLOCKING_STORE=0) on d_gnt.
- RESP -> IDLE on d_rvalid.
REQ-025 in_ready = (state==IDLE) && (!out_valid || out_ready).
- Acceptance occurs on in_valid && in_ready.
- Back-to-back acceptance is permitted.
REQ-026 Non-memory op: out_result = in_ALU_result, out_rd = in_rd, out_valid asserted the cycle after acceptance.
REQ-027 Fault conditions, which issue no d_req and set out_valid the next cycle with out_fault=1, out_result=address and out_rd=0:
- H access with addr[0]=1.
- W access with addr[1:0]!=00.
- Load funct3 of 011, 110 or 111.
- Store funct3 of 011 or higher.
REQ-028 Request format: d_req asserts the cycle after acceptance; d_addr={addr[31:2],2'b00}; d_we=1 for stores; d_be is 0001<<addr[1:0] for B, 0011<<addr[1:0] for H and 1111 for W.
REQ-029 Store data: d_wdata = store data replicated into lanes (B: 4x byte, H: 2x half, W: as is).
REQ-030 d_req, d_we, d_addr, d_be and d_wdata stay constant until the cycle d_gnt=1 is sampled; d_req deasserts the following cycle.
REQ-031 Load completion: on d_rvalid, select the byte or half by addr[1:0], sign-extend for LB/LH and zero-extend for LBU/LHU, then set out_valid next cycle with out_rd=in_rd.
REQ-032 Store completion: out_valid with out_rd=0 and out_result=address.
REQ-033 d_rvalid arrives at the earliest one cycle after d_gnt; d_rvalid is ignored outside RESP.
REQ-034 out_valid, out_result, out_rd and out_fault stay constant while out_valid && !out_ready.
REQ-035 Minimum load latency is 3 cycles: accept at T, d_req/d_gnt at T+1, d_rvalid at T+2, out_valid at T+3.

Reset
REQ-036 On reset low, regardless of clock:
- State returns to IDLE.
- d_req, d_we, d_be, d_addr, d_wdata, out_valid, out_result, out_rd and out_fault clear to 0.
REQ-037 Reset mid-transaction abandons the request; d_rvalid arriving after reset release is ignored.

Structure
REQ-038 Shared package mem_pkg holds:
- mem_op encodings.
- Load/store funct3 constants.
- FSM state encodings.
REQ-039 Combinational sub-module load_extend performs lane selection and sign/zero extension; the FSM, alignment check and store lane formatting live in mem_access_unit.

Verification
REQ-040 LB addr 0x103, d_rdata 0x80FF_0000, immediate gnt -> d_addr 0x100, d_be 1000, out_result 0xFFFF_FF80, out_valid at T+3.
REQ-041 SH addr 0x202, data 0x1234_ABCD, gnt delayed 3 cycles -> d_be 1100, d_wdata 0xABCD_ABCD held stable until gnt, out_rd 0.
REQ-042 LW addr 0x006 -> no d_req, out_fault 1, out_result 0x6, out_rd 0.
REQ-043 Non-memory op result 0x55 with out_ready low for 2 cycles -> out_valid and out_result held, in_ready 0, next op accepted the cycle out_ready rises.
REQ-044 LHU addr 0x10, reset asserted while in RESP, stray d_rvalid after release -> all outputs 0, no out_valid.
